// File: rtl/dmem_pkg.sv
// Shared encodings for the RV32 data memory: load/store codes, FSM states
// and the latched request bundle.
package dmem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SZ_SB = 2'b00;
    localparam logic [1:0] SZ_SH = 2'b01;
    localparam logic [1:0] SZ_SW = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/half of a fetched word and extends it
// according to the load funct3.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = word[7:0];
        unique case (off)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            2'd3: b = word[31:24];
            default: b = word[7:0];
        endcase
    end

    assign h = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = '0;
        unique case (funct3)
            F3_LB:  data = {{24{b[7]}}, b};
            F3_LH:  data = {{16{h[15]}}, h};
            F3_LW:  data = word;
            F3_LBU: data = {24'd0, b};
            F3_LHU: data = {16'd0, h};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_rv32.sv
// Byte-addressable RV32 data memory with sub-word access and stall latency.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses on misalign_err.
module data_memory_rv32
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2,
    parameter int DEBUG_ADDR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  read,
    input  logic [2:0]  write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        busywait,
    output logic [31:0] DEBUG_DATA
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    logic [7:0] mem [DEPTH];

    dmem_req_t req_in;
    dmem_req_t acc;
    logic      req_valid;
    logic      go;

    assign req_in = '{
        ld:    read[3] & ~write[2],
        st:    write[2] & ~read[3],
        f3:    read[2:0],
        sz:    write[1:0],
        addr:  address,
        wdata: writedata
    };
    assign req_valid = req_in.ld | req_in.st;

    generate
        if (LATENCY == 0) begin : g_nolat
            assign acc      = req_in;
            assign go       = reset & req_valid;
            assign busywait = 1'b0;
        end else begin : g_fsm
            localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

            logic [1:0]    state;
            logic [CW-1:0] cnt;
            dmem_req_t     held;

            always_ff @(posedge clock) begin
                if (!reset) begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    held  <= '0;
                end else begin
                    unique case (state)
                        ST_IDLE: begin
                            if (req_valid) begin
                                held  <= req_in;
                                cnt   <= CW'(LATENCY - 1);
                                state <= ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (cnt == '0) state <= ST_DONE;
                            else           cnt   <= cnt - CW'(1);
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end

            assign acc = held;
            assign go  = reset && (state == ST_BUSY) && (cnt == '0);
            assign busywait = reset &&
                ((state == ST_IDLE && req_valid) || state == ST_BUSY);
        end
    endgenerate

    logic [AW-1:0] idx;
    logic [AW-3:0] wi;
    logic [1:0]    off_raw;
    logic [1:0]    off;
    logic          half;
    logic          word;
    logic          blocked;
    logic [3:0]    lanes;
    logic [31:0]   wdat;
    logic [31:0]   raw;
    logic [31:0]   ld_val;
    logic          unused_addr;

    assign idx     = acc.addr[AW-1:0];
    assign wi      = idx[AW-1:2];
    assign off_raw = idx[1:0];
    assign unused_addr = ^acc.addr[31:AW];

    assign half = acc.ld ? (acc.f3[1:0] == 2'b01) : (acc.sz == SZ_SH);
    assign word = acc.ld ? (acc.f3 == F3_LW)      : (acc.sz == SZ_SW);
    assign off  = half ? {off_raw[1], 1'b0} : (word ? 2'b00 : off_raw);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis     = (half & off_raw[0]) | (word & |off_raw);
    assign blocked = mis;

    always_ff @(posedge clock) begin
        if (!reset) misalign_err <= 1'b0;
        else        misalign_err <= go & mis;
    end
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        lanes = '0;
        wdat  = acc.wdata;
        unique case (acc.sz)
            SZ_SB: begin
                lanes = 4'b0001 << off;
                wdat  = {4{acc.wdata[7:0]}};
            end
            SZ_SH: begin
                lanes = off[1] ? 4'b1100 : 4'b0011;
                wdat  = {2{acc.wdata[15:0]}};
            end
            SZ_SW: lanes = 4'b1111;
            default: lanes = '0;
        endcase
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < 4; i++)
            raw[8*i +: 8] = mem[{wi, 2'(i)}];
    end

    dmem_load_align u_align (
        .word   (raw),
        .off    (off),
        .funct3 (acc.f3),
        .data   (ld_val)
    );

    always_ff @(posedge clock) begin
        if (!reset)
            readdata <= '0;
        else if (go && acc.ld)
            readdata <= blocked ? '0 : ld_val;
    end

    // No reset on the array so it can map onto block RAM
    always_ff @(posedge clock) begin
        if (go && acc.st && !blocked) begin
            for (int i = 0; i < 4; i++)
                if (lanes[i]) mem[{wi, 2'(i)}] <= wdat[8*i +: 8];
        end
    end

    localparam logic [AW-1:0] DBG_IDX = AW'(DEBUG_ADDR);
    localparam logic [AW-3:0] DBG_W   = DBG_IDX[AW-1:2];

    assign DEBUG_DATA = {mem[{DBG_W, 2'd3}], mem[{DBG_W, 2'd2}],
                         mem[{DBG_W, 2'd1}], mem[{DBG_W, 2'd0}]};

endmodule

// File: doc/data_memory_rv32.md
Name: data_memory_rv32

Overview:
- Parametrised, byte-addressable data memory for the RV32IM pipeline MEM stage.
- Supports sub-word loads and stores: LB/LH/LW/LBU/LHU and SB/SH/SW.
- Has a configurable access latency, signalled to the pipeline through busywait.
- Drop-in successor to the fixed 256-byte word-only memory; the request encoding stays compatible.

Parameters:
- ADDR_WIDTH, 10, byte-address bits used; depth = 2**ADDR_WIDTH bytes.
- LATENCY, 2, extra stall cycles per access; 0 = no stall.
- DEBUG_ADDR, 0, word-aligned byte address mirrored on DEBUG_DATA.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- read  in  4  [3] = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- write  in  3  [2] = store enable; [1:0] = size (00 SB, 01 SH, 10 SW).
- address  in  32  byte address.
- writedata  in  32  store data; bytes taken from the LSBs.
- readdata  out  32  registered, extended load result.
- busywait  out  1  stall request to the pipeline.
- DEBUG_DATA  out  32  little-endian word at DEBUG_ADDR.

Behaviour:
- Request valid = exactly one of read[3], write[2] set. Both set or neither set = no request.
- Illegal codes (read funct3 011/110/111, write size 11) are accepted as requests, but cause no memory update; a load returns 0.
- Byte order is little-endian. Index = address[ADDR_WIDTH-1:0]; upper address bits are ignored, so addresses wrap modulo depth.
- Stores write only the addressed lanes: SB 1 byte, SH 2 bytes, SW 4 bytes.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
- Misalignment (macro undefined): address bits are silently forced aligned. LH/LHU/SH clear bit 0; LW/SW clear bits [1:0].
- FSM states: IDLE, BUSY, DONE.
  - IDLE, valid request, LATENCY>0: busywait=1 combinationally in the same cycle. Latch op, address and writedata. Load cnt=LATENCY-1; next state BUSY.
  - BUSY: busywait=1. Decrement cnt. When cnt==0, perform the access at that edge (readdata updated for loads); next state DONE.
  - DONE: busywait=0 for exactly one cycle so the pipeline advances. Any request present this cycle is ignored; next state IDLE.
  - Total stall with a held request = LATENCY+1 cycles. Back-to-back requests each take the full sequence.
- LATENCY=0: no FSM. The access is performed at the posedge of the request cycle; busywait is tied 0; readdata is valid from the next cycle.
- readdata holds its value until the next load completes; stores do not change it.
- Reset (reset==0 at a posedge):
  - state becomes IDLE, cnt=0, readdata=0.
  - busywait is forced 0 while reset is low.
  - Reset mid-access aborts the access: no partial store is written.
  - Memory contents are not cleared, which keeps block-RAM inference possible.
- Inputs change only in IDLE. Changes while in BUSY are ignored because the latched copy is used.

Optional Feature:
- DMEM_MISALIGN_TRAP_EN: when defined, adds output port misalign_err (1 bit).
  - A misaligned LH/LHU/LW/SH/SW still runs the normal busywait sequence, but stores write nothing and loads return 0.
  - misalign_err pulses high for one cycle, coincident with the access edge (LATENCY=0: the request cycle; else the DONE-entry edge), and is registered.
  - misalign_err resets to 0.
- When undefined: silent alignment as described above; the port is absent.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (LB, LH, LW, LBU, LHU);
  - store-size constants (SB, SH, SW);
  - the FSM state encoding (IDLE, BUSY, DONE).
- One sub-module, dmem_load_align: combinational. Takes the raw 32-bit word, address[1:0] and funct3, and produces the extended readdata value.

Test Plan:
- SW 0x8421_F0A5 @0x10, then LW @0x10 -> readdata 0x8421_F0A5. With LATENCY=2, busywait is high for exactly 3 cycles per access.
- After test 1: LB @0x10 -> 0xFFFF_FFA5; LBU @0x10 -> 0x0000_00A5; LH @0x12 -> 0xFFFF_8421; LHU @0x12 -> 0x0000_8421.
- SB 0x77 @0x11 over the test-1 word, then LW @0x10 -> 0x8421_77A5, confirming other lanes are untouched.
- ADDR_WIDTH=10: SW 0x1234_5678 @0x400, then LW @0x000 -> 0x1234_5678 (wrap). A request with read[3]=write[2]=1 causes no busywait and no change.
- reset=0 while in BUSY during an SW @0x20 -> next cycle busywait=0, readdata=0; later LW @0x20 returns the old contents.
- With DMEM_MISALIGN_TRAP_EN: LW @0x13 -> readdata 0 and a one-cycle misalign_err pulse. Without it: LW @0x13 returns the word @0x10.
